// File: rtl/program_runner.sv
// program_runner: executes a loaded MOV/MOVL/OUT/HALT program on a local memory, streams OUT words
// through a ready/valid FIFO and checks them against a loaded table of expected values.
module program_runner #(
  parameter int W = 12,
  parameter int NLocal = 64,
  parameter int NProg = 32,
  parameter int NOut = 8,
  parameter int NExp = 16,
  parameter int MaxSteps = 255,
  localparam int LA = $clog2(NLocal),
  localparam int PA = $clog2(NProg),
  localparam int EA = $clog2(NExp),
  localparam int AW = PA > EA ? PA : EA,
  localparam int IW = 2 + LA + W
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_en,
  input  logic          load_sel,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic [EA:0]   n_expected,
  input  logic          start,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          finished,
  output logic          success,
  output logic [15:0]   steps
);
  localparam int OA = $clog2(NOut);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] prog [NProg];
  logic [W-1:0] exp_mem [NExp];
  logic [W-1:0] local_mem [NLocal];
  logic [W-1:0] fifo [NOut];
  logic [PA:0] ip;
  logic [OA-1:0] wr_ptr, rd_ptr;
  logic [OA:0] count;
  logic [EA:0] out_count;
  logic fail;
  logic [IW-1:0] instr;
  logic [1:0] op;
  logic [LA-1:0] a;
  logic [W-1:0] b;
  logic run, limit, at_end, live, halt, full, push, retire, mov, pop, idle, go, drained, mismatch;
  assign instr = prog[ip[PA-1:0]];
  assign op = instr[IW-1 -: 2];
  assign a = instr[W+LA-1 -: LA];
  assign b = instr[W-1:0];
  assign run = state == RUN;
  assign limit = steps == 16'(MaxSteps);
  assign at_end = ip == (PA+1)'(NProg);
  assign live = run && !limit;
  assign halt = live && (at_end || op == 2'd3);
  assign full = count == (OA+1)'(NOut);
  // full is judged before any pop this cycle, so a simultaneous pop never makes room for the push
  assign push = live && !at_end && op == 2'd2 && !full;
  assign retire = live && (at_end || op != 2'd2 || !full);
  assign mov = live && !at_end && !op[1];
  assign pop = out_valid && out_ready;
  assign idle = state == IDLE || state == DONE;
  assign go = start && idle;
  assign drained = state == DRAIN && count == '0;
  assign mismatch = out_count >= n_expected || local_mem[a] != exp_mem[out_count[EA-1:0]];
  assign out_valid = count != '0;
  assign out_data = out_valid ? fifo[rd_ptr] : '0;
  assign busy = run || state == DRAIN;

  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = go ? RUN : (run && (halt || limit)) ? DRAIN : drained ? DONE : state;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ip <= '0;
      steps <= '0;
      out_count <= '0;
      fail <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      finished <= 1'b0;
      success <= 1'b0;
    end else if (go) begin
      ip <= '0;
      steps <= '0;
      out_count <= '0;
      fail <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      finished <= 1'b0;
      success <= 1'b0;
    end else begin
      if (retire && !halt) ip <= ip + (PA+1)'(1);
      if (retire) steps <= steps + 16'(steps != '1);
      if (live == 1'b0 && run) fail <= 1'b1;
      if (push) begin
        out_count <= out_count + (EA+1)'(out_count != '1);
        wr_ptr <= wr_ptr + OA'(1);
        if (mismatch) fail <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + OA'(1);
      count <= count + (OA+1)'(push) - (OA+1)'(pop);
      if (drained) begin
        finished <= 1'b1;
        success <= !fail && out_count == n_expected;
      end
    end
  end

  // memories carry no reset; loads are only accepted while no run is in flight
  always_ff @(posedge clock) begin
    if (load_en && idle && !load_sel) prog[load_addr[PA-1:0]] <= load_data;
    if (load_en && idle && load_sel) exp_mem[load_addr[EA-1:0]] <= load_data[W-1:0];
    if (mov) local_mem[a] <= op[0] ? local_mem[b[LA-1:0]] : b;
    if (push) fifo[wr_ptr] <= local_mem[a];
  end
endmodule

// File: tb/tb_program_runner.sv
// tb_program_runner: directed and random programs on two runners (default and tight step budget),
// checked against a sequential instruction interpreter.
module tb_program_runner;
  localparam int NL = 64, NP = 32, NE = 16;
  logic clock = 0, reset = 1, load_en = 0, load_sel = 0, start = 0, out_ready = 0;
  logic [4:0] load_addr = '0, n_expected = '0;
  logic [19:0] load_data = '0;
  logic ov_a, ov_b, bz_a, bz_b, fn_a, fn_b, sc_a, sc_b;
  logic [11:0] od_a, od_b;
  logic [15:0] st_a, st_b;
  int checks = 0, errors = 0;
  bit rand_ready = 0;
  logic [19:0] pg [NP];
  logic [11:0] ex [NE];
  int nexp;
  logic [11:0] got_a[$], got_b[$], m_out[$];
  int m_steps;
  bit m_ok;

  program_runner #(.NOut(2)) dut_a (.clock(clock), .reset(reset), .load_en(load_en), .load_sel(load_sel),
    .load_addr(load_addr), .load_data(load_data), .n_expected(n_expected), .start(start),
    .out_valid(ov_a), .out_data(od_a), .out_ready(out_ready), .busy(bz_a), .finished(fn_a),
    .success(sc_a), .steps(st_a));
  program_runner #(.NOut(2), .MaxSteps(5)) dut_b (.clock(clock), .reset(reset), .load_en(load_en),
    .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data), .n_expected(n_expected),
    .start(start), .out_valid(ov_b), .out_data(od_b), .out_ready(out_ready), .busy(bz_b),
    .finished(fn_b), .success(sc_b), .steps(st_b));

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (ov_a && out_ready) got_a.push_back(od_a);
    if (ov_b && out_ready) got_b.push_back(od_b);
  end

  function automatic logic [19:0] enc(input int op, input int a, input int b);
    return {op[1:0], a[5:0], b[11:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    if (rand_ready) out_ready = $urandom_range(0, 3) != 0;
  endtask

  // plain interpreter: stall timing is irrelevant to the words, steps and verdict
  task automatic model(input int ms);
    logic [11:0] loc [NL];
    int ip, op, a, b;
    bit fail;
    ip = 0;
    fail = 0;
    m_steps = 0;
    m_out.delete();
    while (1) begin
      if (m_steps == ms) begin fail = 1; break; end
      m_steps++;
      if (ip == NP) break;
      op = int'(pg[ip][19:18]);
      a = int'(pg[ip][17:12]);
      b = int'(pg[ip][11:0]);
      if (op == 3) break;
      if (op == 0) loc[a] = b[11:0];
      else if (op == 1) loc[a] = loc[b % NL];
      else begin
        if (m_out.size() >= nexp || loc[a] !== ex[m_out.size()]) fail = 1;
        m_out.push_back(loc[a]);
      end
      ip++;
    end
    m_ok = !fail && m_out.size() == nexp;
  endtask

  task automatic go(input string tag);
    load_en = 1;
    load_sel = 0;
    for (int i = 0; i < NP; i++) begin load_addr = 5'(i); load_data = pg[i]; cycle(); end
    load_sel = 1;
    for (int i = 0; i < NE; i++) begin load_addr = 5'(i); load_data = 20'(ex[i]); cycle(); end
    load_en = 0;
    n_expected = 5'(nexp);
    got_a.delete();
    got_b.delete();
    start = 1;
    cycle();
    start = 0;
    chk({tag, ".busy"}, 32'(bz_a), 1);
  endtask

  task automatic finish_run(input string tag);
    for (int i = 0; i < 3000 && !(fn_a && fn_b); i++) cycle();
    model(255);
    chk({tag, ".a.finished"}, 32'(fn_a), 1);
    chk({tag, ".a.success"}, 32'(sc_a), 32'(m_ok));
    chk({tag, ".a.steps"}, 32'(st_a), m_steps);
    chk({tag, ".a.count"}, got_a.size(), m_out.size());
    for (int k = 0; k < m_out.size() && k < got_a.size(); k++) chk({tag, ".a.word"}, 32'(got_a[k]), 32'(m_out[k]));
    model(5);
    chk({tag, ".b.finished"}, 32'(fn_b), 1);
    chk({tag, ".b.success"}, 32'(sc_b), 32'(m_ok));
    chk({tag, ".b.steps"}, 32'(st_b), m_steps);
    chk({tag, ".b.count"}, got_b.size(), m_out.size());
    for (int k = 0; k < m_out.size() && k < got_b.size(); k++) chk({tag, ".b.word"}, 32'(got_b[k]), 32'(m_out[k]));
  endtask

  task automatic fill_halt();
    for (int i = 0; i < NP; i++) pg[i] = enc(3, 0, 0);
    for (int i = 0; i < NE; i++) ex[i] = 12'h0;
  endtask

  initial begin
    int wl[$];
    int len, op, a, b, n;
    cycle();
    cycle();
    chk("reset.a", {ov_a, od_a, bz_a, fn_a, sc_a, st_a}, 0);
    chk("reset.b", {ov_b, od_b, bz_b, fn_b, sc_b, st_b}, 0);
    reset = 0;
    out_ready = 1;
    fill_halt();
    pg[0] = enc(0, 0, 1); pg[1] = enc(0, 1, 2); pg[2] = enc(0, 2, 3);
    pg[3] = enc(2, 0, 0); pg[4] = enc(2, 1, 0); pg[5] = enc(2, 2, 0);
    ex[0] = 1; ex[1] = 2; ex[2] = 3; nexp = 3;
    go("t1");
    finish_run("t1");
    chk("t1.steps7", 32'(st_a), 7);
    chk("t1.ok", 32'(sc_a), 1);
    ex[2] = 4;
    go("t2");
    finish_run("t2");
    chk("t2.bad", 32'(sc_a), 0);
    fill_halt();
    for (int i = 0; i < 5; i++) begin pg[i] = enc(0, i, 10 + i); pg[5 + i] = enc(2, i, 0); ex[i] = 12'(10 + i); end
    nexp = 5;
    out_ready = 0;
    go("t3");
    for (int i = 0; i < 10; i++) begin
      load_en = 1; load_sel = i[0]; load_addr = 5'(5 + i); load_data = enc(0, 0, 12'hFFF);
      cycle();
    end
    load_en = 0;
    chk("t3.stall_steps", 32'(st_a), 7);
    chk("t3.stall_valid", 32'(ov_a), 1);
    chk("t3.stall_head", 32'(od_a), 10);
    chk("t3.stall_busy", 32'(bz_a), 1);
    out_ready = 1;
    finish_run("t3");
    chk("t3.ok", 32'(sc_a), 1);
    fill_halt();
    for (int i = 0; i < NP; i++) pg[i] = enc(0, $urandom_range(0, 63), $urandom_range(0, 4095));
    nexp = 0;
    go("t4");
    finish_run("t4");
    chk("t4.end_steps", 32'(st_a), 33);
    chk("t4.limit_steps", 32'(st_b), 5);
    chk("t4.limit_ok", 32'(sc_b), 0);
    fill_halt();
    for (int i = 0; i < 5; i++) begin pg[i] = enc(0, i, 10 + i); pg[5 + i] = enc(2, i, 0); end
    nexp = 5;
    out_ready = 0;
    go("rst");
    cycle(); cycle(); cycle(); cycle();
    reset = 1;
    cycle();
    chk("rst.a", {ov_a, od_a, bz_a, fn_a, sc_a, st_a}, 0);
    reset = 0;
    out_ready = 1;
    fill_halt();
    pg[0] = enc(0, 5, 12'hABC); pg[1] = enc(1, 6, 5); pg[2] = enc(2, 6, 0);
    ex[0] = 12'hABC; nexp = 1;
    go("t5");
    finish_run("t5");
    chk("t5.ok", 32'(sc_a), 1);
    fill_halt();
    pg[0] = enc(0, 3, 7); pg[1] = enc(2, 3, 0); pg[2] = enc(2, 3, 0);
    ex[0] = 7; nexp = 1;
    go("t6");
    finish_run("t6");
    chk("t6.extra", 32'(sc_a), 0);
    rand_ready = 1;
    for (int t = 0; t < 12; t++) begin
      wl.delete();
      len = $urandom_range(1, NP);
      for (int i = 0; i < NP; i++) begin
        op = (i >= len) ? 0 : $urandom_range(0, 2);
        if (wl.size() == 0) op = 0;
        a = $urandom_range(0, 63);
        b = $urandom_range(0, 4095);
        if (op == 1) b = wl[$urandom_range(0, wl.size() - 1)] + 64 * $urandom_range(0, 63);
        if (op == 2) a = wl[$urandom_range(0, wl.size() - 1)];
        if (op != 2) wl.push_back(a);
        pg[i] = (i == len - 1 && t % 4 != 3) ? enc(3, 0, 0) : enc(op, a, b);
      end
      nexp = NE;
      model(1000);
      n = m_out.size() < NE ? m_out.size() : NE;
      for (int k = 0; k < NE; k++) ex[k] = k < n ? m_out[k] : 12'($urandom);
      nexp = n;
      case ($urandom_range(0, 7))
        0: if (n > 0) ex[$urandom_range(0, n - 1)] ^= 12'h001;
        1: nexp = $urandom_range(0, NE);
        default: ;
      endcase
      go("rnd");
      finish_run("rnd");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
